// File: rtl/delay_seq_pkg.sv
// Shared types and helpers for the delay-line sequencer.
package delay_seq_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SKIP  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int unsigned STAT_W = 16;

  // Width of the level and skip counters for a line of the given depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/delay_line_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/delay_line_sequencer.sv
// Sequencer for an external enable-gated delay line: fill, pass-through, zero-fill drain.
// Optional stall statistics are built when DELAY_SEQ_STALL_STATS_EN is defined.
module delay_line_sequencer
  import delay_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          flush,
  output logic                          sr_en,
  output logic [DATA_WIDTH-1:0]         sr_xin,
  input  logic [DATA_WIDTH-1:0]         sr_y,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [cnt_width(DEPTH)-1:0]   level,
  output logic                          busy,
  output logic [STAT_W-1:0]             stat_stall
);

  localparam int unsigned   CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   skip_q, skip_d;
  logic            acc;
  logic            shift;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    acc     = 1'b0;
    shift   = 1'b0;
    // Outputs are forced low for as long as reset is held, not just after the edge.
    if (!rst) begin
      unique case (state_q)
        ST_FILL: begin
          s_ready = !flush;
          acc     = s_valid && s_ready;
          if (acc) begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == DEPTH_C - ONE) state_d = ST_RUN;
          end else if (flush && (cnt_q != '0)) begin
            skip_d  = DEPTH_C - cnt_q;
            state_d = (skip_d == '0) ? ST_FLUSH : ST_SKIP;
          end
        end
        ST_RUN: begin
          m_valid = s_valid && !flush;
          s_ready = m_ready && !flush;
          acc     = s_valid && s_ready;
          m_data  = m_valid ? sr_y : '0;
          cnt_d   = DEPTH_C;
          if (flush) state_d = ST_FLUSH;
        end
        ST_SKIP: begin
          // Push zeros until the k real samples sit at the output end of the line.
          shift = 1'b1;
          if (skip_q <= ONE) begin
            skip_d  = '0;
            state_d = ST_FLUSH;
          end else begin
            skip_d = skip_q - ONE;
          end
        end
        ST_FLUSH: begin
          m_valid = 1'b1;
          if (m_ready) begin
            shift  = 1'b1;
            m_data = sr_y;
            cnt_d  = cnt_q - ONE;
            if (cnt_q <= ONE) state_d = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
    sr_en  = acc || shift;
    sr_xin = acc ? s_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
    end
  end

  assign level = cnt_q;
  assign busy  = (state_q == ST_SKIP) || (state_q == ST_FLUSH);

`ifdef DELAY_SEQ_STALL_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (m_valid && !m_ready),
    .clr   (1'b0),
    .count (stat_stall)
  );
`else
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_delay_line_sequencer.sv
// Scoreboard bench for delay_line_sequencer driving a behavioural model of the delay line.
module tb_delay_line_sequencer;
  import delay_seq_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);
`ifdef DELAY_SEQ_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              flush;
  logic              sr_en;
  logic [DW-1:0]     sr_xin;
  logic [DW-1:0]     sr_y;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [LW-1:0]     level;
  logic              busy;
  logic [STAT_W-1:0] stat_stall;

  delay_line_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .flush      (flush),
    .sr_en      (sr_en),
    .sr_xin     (sr_xin),
    .sr_y       (sr_y),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .level      (level),
    .busy       (busy),
    .stat_stall (stat_stall)
  );

  // Enable-gated delay line; index 0 is the input end.
  logic [DW-1:0] line_q [DEPTH] = '{default: '0};
  assign sr_y = line_q[DEPTH-1];

  always @(posedge clk) begin
    if (sr_en) begin
      line_q[0] <= sr_xin;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] sbq [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, let them settle, then score accepts and emits.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f, input logic r);
    s_valid = v;
    s_data  = d;
    flush   = f;
    m_ready = r;
    #3;
    if (!m_valid) check_eq("m_data_idle", 32'(m_data), 32'd0);
    if (m_valid && m_ready) begin
      if (sbq.size() == 0) check_eq("sb_depth", sbq.size(), 1);
      else check_eq("m_data", 32'(m_data), 32'(sbq.pop_front()));
    end
    if (s_valid && s_ready) sbq.push_back(s_data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b0;
    #2;
    s_valid = 1'b1; m_ready = 1'b1; s_data = 16'h55;
    #1;
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_sr_en", sr_en, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_stall", stat_stall, 0);
    tick();
    rst = 1'b0;

    drive(0, 0, 0, 1);
    check_eq("idle_s_ready", s_ready, 1);
    check_eq("idle_sr_en", sr_en, 0);
    tick();

    // Fill
    for (int i = 1; i <= 4; i++) begin
      drive(1, DW'(i), 0, 1);
      check_eq("fill_m_valid", m_valid, 0);
      check_eq("fill_sr_en", sr_en, 1);
      check_eq("fill_sr_xin", 32'(sr_xin), i);
      tick();
      check_eq("fill_level", level, i);
    end
    check_eq("fill_busy", busy, 0);

    // Stream
    for (int i = 5; i <= 7; i++) begin
      drive(1, DW'(i), 0, 1);
      check_eq("run_m_valid", m_valid, 1);
      check_eq("run_sr_en", sr_en, 1);
      check_eq("run_m_data", 32'(m_data), i - 4);
      check_eq("run_level", level, 4);
      tick();
    end

    // Backpressure
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'd8, 0, 0);
      check_eq("bp_s_ready", s_ready, 0);
      check_eq("bp_sr_en", sr_en, 0);
      check_eq("bp_m_valid", m_valid, 1);
      tick();
    end
    check_eq("bp_line_out", 32'(line_q[DEPTH-1]), 4);
    check_eq("bp_line_in", 32'(line_q[0]), 7);
    check_eq("bp_stall", stat_stall, STATS ? 3 : 0);

    // Full drain; the sample offered alongside flush must be dropped
    drive(1, 16'd99, 1, 1);
    check_eq("fl_s_ready", s_ready, 0);
    check_eq("fl_m_valid", m_valid, 0);
    check_eq("fl_sr_en", sr_en, 0);
    tick();
    check_eq("fl_busy", busy, 1);
    check_eq("fl_level", level, 4);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        drive(0, 0, 0, 0);
        check_eq("fl_hold_m_valid", m_valid, 1);
        check_eq("fl_hold_sr_en", sr_en, 0);
        tick();
      end
      drive(0, 0, 0, 1);
      check_eq("fl_emit_valid", m_valid, 1);
      check_eq("fl_emit_sr_en", sr_en, 1);
      check_eq("fl_emit_xin", 32'(sr_xin), 0);
      check_eq("fl_emit_data", 32'(m_data), 4 + i);
      tick();
    end
    check_eq("fl_done_level", level, 0);
    check_eq("fl_done_busy", busy, 0);
    check_eq("fl_sb_empty", sbq.size(), 0);
    for (int i = 0; i < DEPTH; i++) check_eq("fl_line_zero", 32'(line_q[i]), 0);
    check_eq("fl_stall", stat_stall, STATS ? 4 : 0);

    // Partial drain
    drive(1, 16'd9, 0, 1);  tick();
    drive(1, 16'd10, 0, 1); tick();
    check_eq("pd_level", level, 2);
    drive(1, 16'd77, 1, 1);
    check_eq("pd_s_ready", s_ready, 0);
    check_eq("pd_sr_en", sr_en, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0);
      check_eq("skip_busy", busy, 1);
      check_eq("skip_m_valid", m_valid, 0);
      check_eq("skip_sr_en", sr_en, 1);
      check_eq("skip_level", level, 2);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1);
      check_eq("pd_emit_valid", m_valid, 1);
      check_eq("pd_emit_data", 32'(m_data), 9 + i);
      tick();
    end
    check_eq("pd_done_level", level, 0);
    check_eq("pd_done_busy", busy, 0);
    check_eq("pd_sb_empty", sbq.size(), 0);

    // Reset mid-FLUSH
    drive(1, 16'd11, 0, 1); tick();
    drive(1, 16'd12, 0, 1); tick();
    drive(0, 0, 1, 1); tick();
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 1);
    check_eq("rf_m_valid_pre", m_valid, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("rf_m_valid", m_valid, 0);
    check_eq("rf_m_data", 32'(m_data), 0);
    check_eq("rf_sr_en", sr_en, 0);
    check_eq("rf_s_ready", s_ready, 0);
    check_eq("rf_busy", busy, 0);
    check_eq("rf_level", level, 0);
    sbq.delete();
    tick();
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 1);
    check_eq("rr_s_ready", s_ready, 1);
    check_eq("rr_level", level, 0);
    check_eq("rr_busy", busy, 0);
    check_eq("rr_stall", stat_stall, 0);
    tick();
    for (int i = 13; i <= 16; i++) begin
      drive(1, DW'(i), 0, 1);
      check_eq("rr_fill_m_valid", m_valid, 0);
      tick();
    end
    drive(1, 16'd17, 0, 1);
    check_eq("rr_run_m_valid", m_valid, 1);
    check_eq("rr_run_m_data", 32'(m_data), 13);
    tick();
    drive(0, 0, 0, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
